// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared types and default sizes for the LFSR sequencer (lfsr_seq_ctrl and its deserialiser).
package lfsr_ctrl_pkg;

    localparam int unsigned LFSR_W      = 8;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Control/serial bus between the sequencer (master) and the 8-bit LFSR block (slave).
interface lfsr_seq_ctrl_if
    import lfsr_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_W
);

    logic [WIDTH-1:0] lfsr_seed;
    logic             lfsr_load;
    logic             lfsr_enable;
    logic             lfsr_out_enable;
    logic             lfsr_valid;
    logic             lfsr_out;

    modport master (
        output lfsr_seed,
        output lfsr_load,
        output lfsr_enable,
        output lfsr_out_enable,
        input  lfsr_valid,
        input  lfsr_out
    );

    modport slave (
        input  lfsr_seed,
        input  lfsr_load,
        input  lfsr_enable,
        input  lfsr_out_enable,
        output lfsr_valid,
        output lfsr_out
    );

endinterface

// File: rtl/lfsr_seq_ctrl_deser.sv
// Serial-to-parallel collector: writes each valid bit to result[bit_idx], first bit into the LSB.
module lfsr_seq_deser
    import lfsr_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = LFSR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             valid,
    input  logic             din,
    output logic [WIDTH-1:0] result,
    output logic             full
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [IDX_W-1:0] bit_idx;

    // Asserted in the cycle whose write completes the word, so the owner can leave DRAIN on that edge.
    assign full = valid && (bit_idx == IDX_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            bit_idx <= '0;
            result  <= '0;
        end else if (valid) begin
            result[bit_idx] <= din;
            bit_idx         <= full ? '0 : bit_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Host-side sequencer for the LFSR block: load seed, shift N cycles, drain WIDTH serial bits.
// Optional drain timeout is enabled by defining LFSR_SEQ_TIMEOUT_EN.
module lfsr_seq_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = LFSR_W,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [CNT_W-1:0] shift_count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    lfsr_seq_ctrl_if.master  lfsr
);

    if (WIDTH < 2 || CNT_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("lfsr_seq_ctrl: WIDTH must be >= 2, CNT_W and TIMEOUT >= 1");
    end

    seq_state_e       state;
    seq_state_e       state_n;
    logic [CNT_W-1:0] shift_cnt;
    logic             accept;
    logic             bit_we;
    logic             bit_full;
    logic             timed_out;
    logic             busy_n;
    logic             done_n;
    logic             load_n;
    logic             enable_n;
    logic             out_en_n;

    assign accept = (state == IDLE) && start && !abort;
    assign bit_we = (state == DRAIN) && lfsr.lfsr_valid && !abort;

`ifdef LFSR_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] idle_cnt;

    assign timed_out = (state == DRAIN) && !lfsr.lfsr_valid && (idle_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || (state != DRAIN) || lfsr.lfsr_valid) begin
            idle_cnt <= '0;
        end else if (!timed_out) begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    lfsr_seq_deser #(
        .WIDTH(WIDTH)
    ) u_deser (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .valid (bit_we),
        .din   (lfsr.lfsr_out),
        .result(result),
        .full  (bit_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = (seed_in == '0) ? DONE : LOAD;
            LOAD:    state_n = (shift_cnt != '0) ? SHIFT : DRAIN;
            SHIFT:   if (shift_cnt == CNT_W'(1)) state_n = DRAIN;
            DRAIN:   if (bit_full || timed_out) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_n = IDLE;
        end
    end

    // Outputs are decoded from the next state and registered, so each is valid in the cycle its state is.
    always_comb begin
        busy_n   = (state_n != IDLE);
        done_n   = (state_n == DONE);
        load_n   = (state_n == LOAD);
        enable_n = (state_n == SHIFT);
        out_en_n = (state_n == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy                 <= 1'b0;
            done                 <= 1'b0;
            err                  <= 1'b0;
            shift_cnt            <= '0;
            lfsr.lfsr_seed       <= '0;
            lfsr.lfsr_load       <= 1'b0;
            lfsr.lfsr_enable     <= 1'b0;
            lfsr.lfsr_out_enable <= 1'b0;
        end else begin
            busy                 <= busy_n;
            done                 <= done_n;
            lfsr.lfsr_load       <= load_n;
            lfsr.lfsr_enable     <= enable_n;
            lfsr.lfsr_out_enable <= out_en_n;

            if (accept) begin
                lfsr.lfsr_seed <= seed_in;
                shift_cnt      <= shift_count;
                err            <= (seed_in == '0);
            end else if (timed_out && !abort) begin
                err <= 1'b1;
            end

            if ((state == SHIFT) && !abort) begin
                shift_cnt <= shift_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: directed cases plus randomized transactions vs. a cycle-schedule model.
module tb_lfsr_seq_ctrl;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned PAT_LEN = 48;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] seed_in;
    logic [CNT_W-1:0] shift_count;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    lfsr_seq_ctrl_if #(.WIDTH(WIDTH)) lfsr_bus ();

    lfsr_seq_ctrl #(
        .WIDTH  (WIDTH),
        .CNT_W  (CNT_W),
        .TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .seed_in    (seed_in),
        .shift_count(shift_count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result     (result),
        .lfsr       (lfsr_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic eb, input logic ed, input logic el,
                              input logic ee, input logic eo);
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        check({tag, ".done"}, 32'(done), 32'(ed));
        check({tag, ".load"}, 32'(lfsr_bus.lfsr_load), 32'(el));
        check({tag, ".enable"}, 32'(lfsr_bus.lfsr_enable), 32'(ee));
        check({tag, ".out_enable"}, 32'(lfsr_bus.lfsr_out_enable), 32'(eo));
    endtask

    task automatic junk_lfsr();
        lfsr_bus.lfsr_valid = 1'($urandom);
        lfsr_bus.lfsr_out   = 1'($urandom);
    endtask

    // One sequence with a nonzero seed. The model schedules it from the rules alone:
    // obs 0 = LOAD, obs 1..count = SHIFT, then DRAIN until the WIDTH-th valid bit, then one DONE cycle.
    // mode 0: valid always 1, mode 1: valid 1/0 toggling, other: random valid.
    task automatic run_txn(input string tag, input logic [WIDTH-1:0] seed, input int count,
                           input int unsigned mode, input logic [WIDTH-1:0] data, input int abort_at);
        logic             pat [PAT_LEN];
        int               zrun;
        int               ones;
        int               n_done;
        int               nbits;
        int               idx;
        bit               aborted;
        logic [WIDTH-1:0] exp_res;
        string            t;

        zrun = 0;
        for (int i = 0; i < int'(PAT_LEN); i++) begin
            case (mode)
                0:       pat[i] = 1'b1;
                1:       pat[i] = ((i % 2) == 0);
                default: pat[i] = 1'($urandom);
            endcase
            if (i >= int'(PAT_LEN - WIDTH)) pat[i] = 1'b1;
            if (pat[i]) begin
                zrun = 0;
            end else begin
                zrun++;
                if (zrun >= 8) begin
                    pat[i] = 1'b1;
                    zrun   = 0;
                end
            end
        end

        ones   = 0;
        n_done = 0;
        for (int i = 0; i < int'(PAT_LEN); i++) begin
            if (pat[i] && ones < int'(WIDTH)) begin
                ones++;
                if (ones == int'(WIDTH)) n_done = count + 2 + i;
            end
        end

        seed_in     = seed;
        shift_count = CNT_W'(count);
        start       = 1'b1;
        abort       = 1'b0;
        junk_lfsr();
        tick();

        exp_res = '0;
        nbits   = 0;
        aborted = 1'b0;
        for (int n = 0; n <= n_done; n++) begin
            if (aborted) break;
            t = $sformatf("%s.c%0d", tag, n);
            check_ctrl(t, 1'b1, n == n_done, n == 0, (n >= 1) && (n <= count),
                       (n >= count + 1) && (n < n_done));
            check({t, ".seed"}, 32'(lfsr_bus.lfsr_seed), 32'(seed));
            check({t, ".err"}, 32'(err), 32'(0));
            if (n == n_done) check({t, ".result"}, 32'(result), 32'(data));

            start       = 1'($urandom);
            seed_in     = WIDTH'($urandom);
            shift_count = CNT_W'($urandom);
            abort       = (n == abort_at);
            junk_lfsr();
            if ((n >= count + 1) && (n < n_done)) begin
                idx = n - count - 1;
                lfsr_bus.lfsr_valid = abort ? 1'b0 : pat[idx];
                if (pat[idx] && !abort) begin
                    lfsr_bus.lfsr_out = data[nbits];
                    exp_res[nbits]    = data[nbits];
                    nbits++;
                end
            end
            tick();
            if (n == abort_at) aborted = 1'b1;
        end

        start = 1'b0;
        abort = 1'b0;
        t = {tag, ".end"};
        check_ctrl(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check({t, ".result"}, 32'(result), 32'(aborted ? exp_res : data));
        check({t, ".err"}, 32'(err), 32'(0));
    endtask

    initial begin
        logic             done_seen;
        logic [WIDTH-1:0] d;

        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        seed_in     = '0;
        shift_count = '0;
        junk_lfsr();
        repeat (3) tick();
        check_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.err", 32'(err), 32'(0));
        check("reset.result", 32'(result), 32'(0));
        check("reset.seed", 32'(lfsr_bus.lfsr_seed), 32'(0));
        reset = 1'b0;
        tick();

        run_txn("basic", 8'b1001_0010, 8, 0, WIDTH'($urandom), -1);
        run_txn("count0", 8'h5A, 0, 0, WIDTH'($urandom), -1);

        // Zero seed: error, immediate DONE, LFSR never touched.
        seed_in     = '0;
        shift_count = CNT_W'(5);
        start       = 1'b1;
        tick();
        check_ctrl("zseed.c0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("zseed.c0.err", 32'(err), 32'(1));
        check("zseed.c0.result", 32'(result), 32'(0));
        start = 1'b0;
        tick();
        check_ctrl("zseed.c1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("zseed.c1.err", 32'(err), 32'(1));

        run_txn("toggle", 8'hC3, 3, 1, 8'h4D, -1);
        run_txn("abort_shift", 8'h37, 10, 0, WIDTH'($urandom), 3);
        run_txn("abort_drain", 8'h81, 0, 0, WIDTH'($urandom), 4);

        // start and abort together in IDLE: abort wins.
        seed_in = 8'h11;
        start   = 1'b1;
        abort   = 1'b1;
        tick();
        check_ctrl("start_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        tick();
        check_ctrl("start_abort.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            run_txn($sformatf("rnd%0d", k), WIDTH'($urandom_range(1, 255)), int'($urandom_range(0, 20)),
                    2, WIDTH'($urandom), -1);
        end

        // Reset in the middle of DRAIN after three bits have landed.
        seed_in     = 8'h6C;
        shift_count = '0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        lfsr_bus.lfsr_valid = 1'b1;
        lfsr_bus.lfsr_out   = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check_ctrl("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midreset.result", 32'(result), 32'(0));
        check("midreset.seed", 32'(lfsr_bus.lfsr_seed), 32'(0));
        check("midreset.err", 32'(err), 32'(0));
        reset = 1'b0;
        tick();

        // Valid held low throughout DRAIN.
        d           = 8'hA5;
        seed_in     = d;
        shift_count = '0;
        start       = 1'b1;
        lfsr_bus.lfsr_valid = 1'b0;
        tick();
        start     = 1'b0;
        done_seen = 1'b0;
`ifdef LFSR_SEQ_TIMEOUT_EN
        for (int n = 0; n <= 17; n++) begin
            check_ctrl($sformatf("timeout.c%0d", n), 1'b1, n == 17, n == 0, 1'b0, (n >= 1) && (n < 17));
            tick();
        end
        check_ctrl("timeout.end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("timeout.err", 32'(err), 32'(1));
        check("timeout.result", 32'(result), 32'(0));
`else
        for (int n = 0; n < 100; n++) begin
            done_seen = done_seen | done;
            tick();
        end
        check("stall.busy", 32'(busy), 32'(1));
        check("stall.out_enable", 32'(lfsr_bus.lfsr_out_enable), 32'(1));
        check("stall.done_seen", 32'(done_seen), 32'(0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_ctrl("stall.abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stall.err", 32'(err), 32'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
